// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the sequential ALU.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the operand registers and the sequential ALU.
// Latency: n/a (wires only).
// Backpressure: requester must hold off while busy; start is ignored then.
interface seq_alu_if #(
    parameter int W = 8
);
    logic           start;
    logic [W-1:0]   opA;
    logic [W-1:0]   opB;
    logic [1:0]     opcode;
    logic           busy;
    logic           done;
    logic [2*W-1:0] res;

    modport master (
        output start, opA, opB, opcode,
        input  busy, done, res
    );

    modport slave (
        input  start, opA, opB, opcode,
        output busy, done, res
    );
endinterface

// File: rtl/mul_shift_add.sv
// Unsigned W x W shift-add multiplier datapath: one partial product per step.
// Latency: W steps after load; product is the accumulator value after the current step.
// Backpressure: none; the controller decides when to load and step.
module mul_shift_add #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           last
);

    localparam logic [W-1:0] LAST_STEP = (W)'(W - 1);
    localparam logic [W-1:0] CNT_ONE   = (W)'(1);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0] acc_step;

    // Next-state for the shift-add datapath; the accumulator only grows on step.
    always_comb begin
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step;
            cnt_d    = cnt_q + CNT_ONE;
        end
    end

    // The finished product is taken from the step result so the controller
    // can capture it on the same edge as the final step.
    assign product = acc_step;
    assign last    = step && (cnt_q == LAST_STEP);

    // Datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: ADD/SUB/AND in one cycle, MUL via a W-step shift-add unit.
// Latency: 1 cycle for ADD/SUB/AND, W cycles for MUL; done pulses with each new res.
// Backpressure: busy=1 during MUL; start and operands are ignored until it drops.
module seq_alu
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic    clk,
    input  logic    rst,
    seq_alu_if.slave bus
);

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [2*W-1:0] res_q, res_d;

    logic           mul_load;
    logic           mul_step;
    logic           mul_last;
    logic [2*W-1:0] mul_product;
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;

    assign a_ext = {{W{1'b0}}, bus.opA};
    assign b_ext = {{W{1'b0}}, bus.opB};

    mul_shift_add #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .step    (mul_step),
        .a       (bus.opA),
        .b       (bus.opB),
        .product (mul_product),
        .last    (mul_last)
    );

    // Control: accept only in IDLE, finish single-cycle ops immediately,
    // and step the multiplier until its final step.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        res_d    = res_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.opcode)
                        OP_ADD: begin
                            res_d  = a_ext + b_ext;
                            done_d = 1'b1;
                        end
                        OP_SUB: begin
                            // 2W-bit wraparound yields the sign-extended difference.
                            res_d  = a_ext - b_ext;
                            done_d = 1'b1;
                        end
                        OP_AND: begin
                            res_d  = a_ext & b_ext;
                            done_d = 1'b1;
                        end
                        OP_MUL: begin
                            mul_load = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = S_MUL_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL_RUN: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    res_d   = mul_product;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM and registered outputs; reset wins over any request on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.res  = res_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized scoreboard bench for seq_alu at W=8.
// Latency: n/a.
// Backpressure: driver waits on busy before each request.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [15:0] res;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_alu_if #(.W(W)) bus ();

    seq_alu #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests   = 0;
    int          fails   = 0;
    int          cyc     = 0;
    int          mul_e0  = -1000;
    logic [15:0] exp_res = '0;
    exp_t        sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic logic [15:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned r;
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_MUL:  r = x * y;
            default: r = x & y;
        endcase
        return r[15:0];
    endfunction

    // Monitor: every cycle, checks busy, done and res against expectations.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            chk("busy", {31'b0, bus.busy}, {31'b0, (cyc >= mul_e0) && (cyc < mul_e0 + W)});
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("done_missing", {31'b0, bus.done}, 32'd1);
                exp_res = sb[0].res;
                void'(sb.pop_front());
            end else begin
                chk("done_spurious", {31'b0, bus.done}, 32'd0);
            end
            chk("res", {16'b0, bus.res}, {16'b0, exp_res});
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'($urandom_range(0, 1));
        sb.delete();
        mul_e0  = -1000;
        exp_res = '0;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_res", {16'b0, bus.res}, 32'd0);
    endtask

    // Waits (at negedges) for busy to drop, then drives one request for one edge.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input bit noise);
        exp_t e;
        int   guard = 0;
        while (bus.busy === 1'b1) begin
            guard++;
            if (guard > 4 * W) begin
                tests++;
                fails++;
                $display("FAIL busy_timeout: busy still high after %0d cycles", guard);
                break;
            end
            if (noise) begin
                bus.start  = 1'($urandom_range(0, 1));
                bus.opA    = 8'($urandom);
                bus.opB    = 8'($urandom);
                bus.opcode = 2'($urandom);
                if ($urandom_range(0, 39) == 0) begin
                    do_reset();
                    continue;
                end
            end
            @(negedge clk);
        end
        bus.start  = 1'b1;
        bus.opA    = a;
        bus.opB    = b;
        bus.opcode = op;
        e.res = model(op, a, b);
        e.due = cyc + 1 + ((op == OP_MUL) ? W : 0);
        sb.push_back(e);
        if (op == OP_MUL) mul_e0 = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (bus.done !== 1'b1 && g < W + 4) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", {31'b0, bus.done}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.opA    = '0;
        bus.opB    = '0;
        bus.opcode = OP_ADD;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_done", {31'b0, bus.done}, 32'd0);
        chk("reset_res", {16'b0, bus.res}, 32'd0);

        // ADD 67 + 33
        issue(OP_ADD, 8'd67, 8'd33, 1'b0);
        chk("add_done", {31'b0, bus.done}, 32'd1);
        chk("add_res", {16'b0, bus.res}, 32'h0064);

        // MUL A3 x DA with opA disturbed mid-run
        issue(OP_MUL, 8'hA3, 8'hDA, 1'b0);
        chk("mul_busy", {31'b0, bus.busy}, 32'd1);
        bus.opA = 8'h00;
        wait_done();
        chk("mul_res", {16'b0, bus.res}, 32'h8ACE);

        // SUB 54 - DA, AND A3 & DA
        issue(OP_SUB, 8'd54, 8'hDA, 1'b0);
        chk("sub_res", {16'b0, bus.res}, 32'hFF5C);
        issue(OP_AND, 8'hA3, 8'hDA, 1'b0);
        chk("and_res", {16'b0, bus.res}, 32'h0082);

        // MUL 67 x 33 with a stray ADD request mid-run, then ADD in the done cycle
        issue(OP_MUL, 8'd67, 8'd33, 1'b0);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.opcode = OP_ADD;
        bus.opA    = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        chk("mul2_res", {16'b0, bus.res}, 32'h08A3);
        issue(OP_ADD, 8'hFF, 8'hFF, 1'b0);
        chk("add_after_done", {16'b0, bus.res}, 32'h01FE);
        chk("add_after_done_pulse", {31'b0, bus.done}, 32'd1);

        // Reset in the middle of MUL FF x FF, then a clean repeat
        issue(OP_MUL, 8'hFF, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        do_reset();
        repeat (W + 2) @(negedge clk);
        issue(OP_MUL, 8'hFF, 8'hFF, 1'b0);
        wait_done();
        chk("mul_ff_res", {16'b0, bus.res}, 32'hFE01);

        // Randomized traffic with gaps, back-to-back requests, noise and resets
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(2'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        end

        repeat (W + 4) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

- Parametrised, clocked successor to the team's combinational 8-bit ALU.
- Accepts two W-bit operands and a 2-bit opcode under a start/done handshake and produces a 2W-bit result.
- ADD, SUB and AND complete in one cycle; MUL runs as a W-cycle shift-add sequence, replacing the single-cycle array multiplier.
- Sits between operand registers and the result bus of the datapath.

## Interface

- W, default 8 — operand width; legal range 2..32.
- clk  in  1  — the single clock; all state changes on its rising edge.
- rst  in  1  — reset, synchronous, active-high.
- start  in  1  — request; sampled each rising edge; accepted only when busy=0.
- opA  in  W  — operand A, unsigned; sampled on the accepting edge.
- opB  in  W  — operand B, unsigned; sampled on the accepting edge.
- opcode  in  2  — operation select, sampled on the accepting edge:
  - 00 = ADD
  - 01 = MUL
  - 10 = SUB
  - 11 = AND
- busy  out  1  — high while a MUL is in progress.
- done  out  1  — one-cycle pulse when res holds a new result.
- res  out  2W  — result; holds its value until the next completion.

## Operation

- **States**
  - IDLE: busy=0. The block waits for start.
  - MUL_RUN: busy=1. A W-bit step counter runs. The block returns to IDLE on the final step.
- **Accept**
  - A request is accepted when start=1 and state=IDLE, with rst=0.
  - While busy=1, start is ignored and the operands and opcode are not re-sampled.
- **ADD**
  - res = zero-extended (opA + opB).
  - Carry lands in bit W; bits 2W-1..W+1 are 0.
- **SUB**
  - res = (opA − opB) in two's complement, sign-extended to 2W bits.
  - Both operands are zero-extended to 2W bits before subtracting.
- **AND**
  - res = zero-extended (opA & opB).
- **MUL**
  - Unsigned product. Operands are latched on the accepting edge; the accumulator clears to 0.
  - Each MUL_RUN cycle examines the current multiplier LSB. When it is 1, the shifted multiplicand is added to the accumulator. The multiplier then shifts right by 1 and the multiplicand shifts left by 1.
  - After W steps the accumulator equals opA × opB exactly. This fits 2W bits with no overflow.
- **Results**
  - res is written only on completion. Intermediate accumulator values never appear on res.
  - done=1 for exactly one cycle per completed operation.
- **Reset values**
  - state=IDLE, busy=0, done=0, res=0.
  - Accumulator and counter are cleared to 0.

## Timing

- Let E0 be the accepting edge.
- **ADD/SUB/AND**
  - res and done are updated at E0, so they are visible in the cycle after E0. Latency is 1.
  - busy stays 0 throughout.
  - Back-to-back start on consecutive edges is allowed; each completes one cycle later with its own done pulse.
- **MUL**
  - busy rises at E0.
  - Steps execute on edges E1..EW.
  - At EW: res ← product, done ← 1, busy ← 0.
  - Latency is W cycles from the accepting edge; W=8 gives 8.
- **Start coinciding with done**
  - A start in the cycle where done=1 is accepted, because busy is already 0 then.
  - That done pulse still deasserts after one cycle unless the new operation is single-cycle. In that case done stays high for one more cycle carrying the new res.
- **Reset mid-MUL**
  - rst=1 at any edge forces the reset values at that edge.
  - The in-flight operation is discarded with no done pulse.
  - Reset takes priority over start on the same edge.
- **Operand changes**
  - Changes to opA, opB or opcode while busy=1 have no effect.
- **MUL with a zero operand**
  - The operation still takes W cycles and produces res=0.

## Structure

- Package alu_pkg holds:
  - the opcode constants OP_ADD=2'b00, OP_MUL=2'b01, OP_SUB=2'b10, OP_AND=2'b11;
  - the state encoding constants S_IDLE and S_MUL_RUN.
- One sub-module, mul_shift_add (parameter W), contains the multiplicand, multiplier, accumulator and step counter.
  - Inputs: load, step.
  - Outputs: product[2W-1:0], last.
  - seq_alu owns the FSM, the single-cycle ops, the res register and the done/busy logic.

## Test plan

All scenarios use W=8.

- ADD opA=67, opB=33, start for 1 cycle → done in the next cycle, res=16'h0064, busy never 1.
- MUL opA=8'hA3, opB=8'hDA → busy high for 8 cycles, done on the 8th edge after accept, res=16'h8ACE (35534). Changing opA to 8'h00 mid-run leaves res unchanged.
- SUB opA=54, opB=8'hDA → res=16'hFF5C (−164).
- AND opA=8'hA3, opB=8'hDA → res=16'h0082.
- MUL 67×33, with start re-asserted at cycle 3 with opcode ADD:
  - the second start is ignored; res=16'h08A3 after 8 cycles;
  - a start in the done cycle is accepted, and ADD 255+255 then gives res=16'h01FE.
- Assert rst at cycle 4 of MUL 8'hFF×8'hFF → busy=0, done=0, res=0 on the next cycle, and no done pulse follows. A fresh MUL 8'hFF×8'hFF then gives res=16'hFE01.
